// File: rtl/chain_rx_pkg.sv
// Shared types and decode helper for the delay-chain receive end.
package chain_rx_pkg;

    localparam int TAPS_DEF  = 32;
    localparam int DELAY_DEF = 4;
    localparam int MAX_TAPS  = 256;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SYNC   = 2'd2,
        DECODE = 2'd3
    } rx_state_e;

    // Returns the unbroken run length from bit 0 of taps equal to lvl; first_mis
    // is the index of the first mismatching tap, or n when the run covers all taps.
    function automatic int leading_match_count(input logic [MAX_TAPS-1:0] snap,
                                               input logic lvl, input int n,
                                               output int first_mis);
        int  cnt;
        bit  broken;
        cnt    = 0;
        broken = 1'b0;
        for (int i = 0; i < MAX_TAPS; i++) begin
            if (i < n && !broken) begin
                if (snap[i] == lvl) cnt = cnt + 1;
                else                broken = 1'b1;
            end
        end
        first_mis = cnt;
        return cnt;
    endfunction

endpackage

// File: rtl/chain_tap_sync.sv
// Two-flop synchroniser for the asynchronous chain tap levels.
module chain_tap_sync #(
    parameter int TAPS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [TAPS-1:0] taps,
    output logic [TAPS-1:0] sync2
);

    logic [TAPS-1:0] s1_q, s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= taps;
            s2_q <= s1_q;
        end
    end

    assign sync2 = s2_q;

endmodule

// File: rtl/chain_edge_receiver.sv
// Launches an edge into the tapped delay chain, waits, snapshots the taps and
// decodes the thermometer code into an edge position with bubble/overflow flags.
module chain_edge_receiver
    import chain_rx_pkg::*;
#(
    parameter int TAPS         = TAPS_DEF,
    parameter int CNT_W        = 6,
    parameter int DELAY_CYCLES = DELAY_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [TAPS-1:0]  taps,
    output logic             Next_Edge_LowV,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] count,
    output logic             bubble_err,
    output logic             ovf
);

    rx_state_e        state_q, state_d;
    logic             nel_q, nel_d;
    logic [7:0]       wcnt_q, wcnt_d;
    logic             scnt_q, scnt_d;
    logic [TAPS-1:0]  snap_q, snap_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bub_q, bub_d;
    logic             ovf_q, ovf_d;
    logic [TAPS-1:0]  sync2;

    int               lead;
    int               first_mis;
    logic             dec_ovf;
    logic             dec_bub;

    chain_tap_sync #(.TAPS(TAPS)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .taps  (taps),
        .sync2 (sync2)
    );

    // Decode against the level just launched, which is still held in nel_q.
    always_comb begin
        first_mis = 0;
        lead      = leading_match_count(MAX_TAPS'(snap_q), nel_q, TAPS, first_mis);
        dec_ovf   = (lead == TAPS);
        dec_bub   = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (i > first_mis && snap_q[i] == nel_q) dec_bub = 1'b1;
        end
        if (dec_ovf) dec_bub = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        nel_d   = nel_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        snap_d  = snap_q;
        valid_d = 1'b0;
        count_d = count_q;
        bub_d   = bub_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    nel_d   = ~nel_q;
                    wcnt_d  = 8'(DELAY_CYCLES - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wcnt_q == 8'd0) begin
                    scnt_d  = 1'b1;
                    state_d = SYNC;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                end
            end
            SYNC: begin
                if (scnt_q) begin
                    scnt_d = 1'b0;
                end else begin
                    snap_d  = sync2;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                count_d = CNT_W'(lead);
                bub_d   = dec_bub;
                ovf_d   = dec_ovf;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            nel_q   <= 1'b0;
            wcnt_q  <= '0;
            scnt_q  <= 1'b0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            bub_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nel_q   <= nel_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            count_q <= count_d;
            bub_q   <= bub_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Next_Edge_LowV = nel_q;
    assign busy           = (state_q != IDLE);
    assign valid          = valid_q;
    assign count          = count_q;
    assign bubble_err     = bub_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_chain_edge_receiver.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on valid.
module tb_chain_edge_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] taps;
    logic        nel, busy, valid, bub, ovf;
    logic [5:0]  count;

    typedef struct {
        int         edge_no;
        logic [5:0] count;
        logic       bub;
        logic       ovf;
        logic       nel;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    chain_edge_receiver dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .taps           (taps),
        .Next_Edge_LowV (nel),
        .busy           (busy),
        .valid          (valid),
        .count          (count),
        .bubble_err     (bub),
        .ovf            (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got valid=1 expected no result (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc != e.edge_no || count != e.count || bub != e.bub ||
                    ovf != e.ovf || nel != e.nel) begin
                    failures++;
                    $display("FAIL result: got edge=%0d count=%0d bub=%0b ovf=%0b lvl=%0b expected edge=%0d count=%0d bub=%0b ovf=%0b lvl=%0b",
                             cyc, count, bub, ovf, nel, e.edge_no, e.count, e.bub, e.ovf, e.nel);
                end
            end
        end
    end

    // Called #1 after an edge; the next edge is E0. Returns #1 after the valid edge.
    task automatic run_meas(input logic [31:0] tv, input bit hold,
                            input int c, input bit b, input bit o, input bit l);
        exp_t e;
        int   e0, n;
        start     = 1'b1;
        e0        = cyc + 1;
        e.edge_no = e0 + 7;
        e.count   = 6'(c);
        e.bub     = b;
        e.ovf     = o;
        e.nel     = l;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("launch_level", int'(nel), int'(l));
        chk("busy_after_E0", int'(busy), 1);
        taps = tv;
        if (!hold) start = 1'b0;
        n = 0;
        while (valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (hold && cyc == e0 + 6) start = 1'b0;
        end
        if (valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL timeout: got no valid expected valid within 20 cycles");
        end
        chk("busy_at_valid", int'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        taps  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_nel", int'(nel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_bub", int'(bub), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_meas(32'h0000_1FFF, 1'b0, 13, 1'b0, 1'b0, 1'b1);  // rising
        run_meas(32'hFFFF_FFF0, 1'b0,  4, 1'b0, 1'b0, 1'b0);  // falling, back-to-back
        run_meas(32'hFFFF_FFFF, 1'b0, 32, 1'b0, 1'b1, 1'b1);  // overflow
        run_meas(32'hFFFF_FFFF, 1'b0,  0, 1'b0, 1'b0, 1'b0);  // falling, no match at bit 0
        run_meas(32'h0000_0107, 1'b0,  3, 1'b1, 1'b0, 1'b1);  // bubble
        run_meas(32'h0000_0000, 1'b1, 32, 1'b0, 1'b1, 1'b0);  // start held while busy
        @(posedge clk); #1;
        chk("valid_one_cycle", int'(valid), 0);
        chk("count_holds", int'(count), 32);
        chk("ovf_holds", int'(ovf), 1);

        // Abort a rising measurement with reset sampled at E2.
        taps  = 32'h0000_0007;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort_launch", int'(nel), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_nel", int'(nel), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        repeat (10) @(posedge clk);
        #1;
        run_meas(32'h0000_0007, 1'b0, 3, 1'b0, 1'b0, 1'b1);  // rising again after reset

        repeat (10) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chain_edge_receiver.md
Name: chain_edge_receiver

Overview:
- Receive end of the tapped inverter delay chain.
- Launches an edge on Next_Edge_LowV, which the chain driver buffers into the chain. After a programmed wait, it samples the asynchronous chain taps through a 2-flop synchroniser.
- Decodes the thermometer snapshot into a binary edge-position count, with bubble and overflow flags.
- Sits between the measurement controller (start/valid handshake) and the analog delay line.

Parameters:
- TAPS, 32, number of chain taps sampled.
- CNT_W, 6, count width; must equal $clog2(TAPS+1).
- DELAY_CYCLES, 4, clk cycles spent in WAIT after launch; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active low.
- start  input  1  measurement request; sampled only in IDLE.
- taps  input  TAPS  asynchronous tap levels from the chain; bit 0 is nearest the driver.
- Next_Edge_LowV  output  1  launch level to the chain driver; toggles once per accepted start.
- busy  output  1  high whenever state is not IDLE.
- valid  output  1  one-cycle pulse marking count/bubble_err/ovf as new.
- count  output  CNT_W  number of leading taps, from bit 0, at the launched level (0..TAPS).
- bubble_err  output  1  a tap beyond the first mismatch also shows the launched level.
- ovf  output  1  count == TAPS; the edge passed the whole chain.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - Next_Edge_LowV, busy, valid, count, bubble_err, ovf, wait counter and snapshot all go to 0.
  - Synchroniser flops clear.
  - Reset mid-measurement aborts it with no valid pulse; the next launch is rising.
- Synchroniser: taps pass through two flops every cycle, regardless of state (sync2 = taps delayed 2 cycles).
- States: IDLE, WAIT, SYNC, DECODE.
- IDLE:
  - start=1 at edge E0 toggles Next_Edge_LowV, loads wcnt=DELAY_CYCLES-1 and moves to WAIT.
  - valid drops to 0 on any IDLE edge without a new result.
- WAIT:
  - Each edge decrements wcnt.
  - The edge that sees wcnt==0 moves to SYNC with scnt=1. WAIT therefore covers edges E1..E_D.
- SYNC:
  - Edge E_{D+1}: scnt becomes 0.
  - Edge E_{D+2}: snap<=sync2, move to DECODE.
- DECODE:
  - Edge E_{D+3} registers count, bubble_err and ovf, pulses valid=1 for one cycle, and returns to IDLE.
  - Latency from the accepting edge to valid high is DELAY_CYCLES+3 edges (7 with defaults).
- Decode rules, with lvl = current Next_Edge_LowV:
  - match[i] = (snap[i]==lvl).
  - count = length of the unbroken match run starting at bit 0.
  - ovf = (count==TAPS).
  - bubble_err = OR of match[i] for i>count; 0 when ovf.
- Launch polarity alternates: odd-numbered measurements launch rising, even-numbered launch falling. Decode always uses the newly launched level.
- start while busy is ignored, not queued. start in the valid cycle (state IDLE) is accepted, so back-to-back measurements are legal.
- count, bubble_err and ovf hold their values until the next DECODE edge or reset.

Decomposition:
- Package chain_rx_pkg holds:
  - the state enum (IDLE/WAIT/SYNC/DECODE, 2-bit);
  - default TAPS and DELAY_CYCLES constants;
  - a function leading_match_count(snap, lvl) returning count, plus the first-mismatch index used for bubble detection.
- One sub-module, chain_tap_sync: parameterised TAPS-wide 2-flop synchroniser with the same clk/rst_n. The FSM and decode stay in the top module.

Test Plan:
- Reset hold: rst_n=0 for 3 cycles -> Next_Edge_LowV=0, busy=0, valid=0, count=0, bubble_err=0, ovf=0.
- Rising measurement: taps=0 at start. Pulse start at E0, then drive taps[12:0]=1 (rest 0) from E1 -> Next_Edge_LowV=1 after E0, busy for E0..E6, valid=1 only after E7 with count=13, bubble_err=0, ovf=0.
- Falling measurement immediately after (start in the valid cycle): taps=32'hFFFFFFF0 -> Next_Edge_LowV=0, count=4, no flags, valid 7 edges later.
- Overflow: rising launch with taps all ones -> count=32, ovf=1, bubble_err=0.
- Bubble: rising launch with taps=32'h0000_0107 -> count=3, bubble_err=1, ovf=0.
- Abuse:
  - start held high during busy -> exactly one valid per measurement.
  - rst_n=0 at E2 of a WAIT -> no valid pulse, Next_Edge_LowV=0; the next start launches rising.
